ascii_digit_tx_sequencer: RTL
=============================

Name: ascii_digit_tx_sequencer

Overview:
- Consumes the three ASCII digit bytes (hundreds, tens, ones) produced by the binary-to-ASCII decoding stage for one MxV result element.
- Serializes them, with optional leading-zero suppression and a separator or CR/LF terminator, into a byte stream for the UART transmitter.
- Sits between the result decoder and the UART TX byte interface.
- Accepts one element per start; a valid/ready handshake on the output tolerates UART backpressure.

Parameters:
- SEPARATOR, 8'h2C, byte sent after an element that is not last in the vector (',').
- SUPPRESS_ZEROS, 1, 1 = drop leading '0' digits (ones digit always sent); 0 = always send three digits.
- EOL_CR, 8'h0D, first terminator byte after the last element.
- EOL_LF, 8'h0A, second terminator byte after the last element.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to send one element; honoured only while in_ready=1.
- last  input  1  element is last of vector; sampled with start.
- hundreds  input  8  ASCII hundreds digit ('0'..'2'); sampled with start.
- tens  input  8  ASCII tens digit; sampled with start.
- ones  input  8  ASCII ones digit; sampled with start.
- in_ready  output  1  high in IDLE only.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  UART TX accepts byte when tx_valid&&tx_ready at a rising edge.
- done  output  1  one-cycle pulse after the final byte of the element is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - Outputs: tx_valid=0, tx_data=8'h00, done=0, in_ready=1.
  - Captured digit and last registers clear.
  - Reset mid-transfer abandons the element; no byte is re-sent after reset release.
- FSM states: IDLE, SEND_H, SEND_T, SEND_O, SEND_SEP, SEND_CR, SEND_LF, DONE.
- Sequences from IDLE:
  - IDLE with start=1: capture hundreds/tens/ones/last at the edge and go to the first send state.
  - First send state with SUPPRESS_ZEROS=1: SEND_H if hundreds!='0'; else SEND_T if tens!='0'; else SEND_O.
  - First send state with SUPPRESS_ZEROS=0: always SEND_H.
  - SEND_H then SEND_T; SEND_T then SEND_O.
  - SEND_O then SEND_SEP if last=0, else SEND_CR.
  - SEND_CR then SEND_LF.
  - SEND_SEP or SEND_LF then DONE.
  - DONE then IDLE after 1 cycle.
- Zero suppression: tens is never skipped once hundreds has been sent (e.g. 105 sends '1','0','5').
- Output timing:
  - In each SEND_* state, tx_valid=1 and tx_data holds that state's byte, registered.
  - A state advances only on the edge where tx_valid&&tx_ready.
  - tx_data and tx_valid stay stable while tx_ready=0.
- Latency: start sampled at edge N; first byte is valid in cycle N+1. With tx_ready held at 1, one byte per cycle.
- done: high for exactly the DONE cycle. in_ready=0 from the edge that accepts start through DONE, and returns to 1 in the cycle after DONE.
- Boundary cases:
  - start while in_ready=0 is ignored; no queuing.
  - Digit input changes after capture have no effect.
  - Input 0 with suppression sends only '0'.
  - tx_ready high while tx_valid=0 has no effect.
- Byte count per element: 2..4 with last=0; 3..5 with last=1.

Decomposition:
- Shared package holds:
  - the state enum typedef;
  - ASCII constants ASCII_ZERO=8'h30, ASCII_COMMA, ASCII_CR, ASCII_LF, used as parameter defaults.
- No sub-module: the block is one registered FSM with a byte mux.

Test Plan:
- 255, last=0, tx_ready=1 -> '2','5','5',',' on 4 consecutive cycles (8'h32,8'h35,8'h35,8'h2C), then done pulse, then in_ready=1.
- 7, last=1, SUPPRESS_ZEROS=1 -> '7',CR,LF (8'h37,8'h0D,8'h0A). Same input with SUPPRESS_ZEROS=0 -> '0','0','7',CR,LF.
- 0 and 105, last=0 -> '0',',' and '1','0','5',','. The middle zero is kept.
- 40, last=1, tx_ready low for 3 cycles on every byte -> each byte is held stable on tx_data while stalled; sequence '4','0',CR,LF is unchanged; done occurs only after LF is accepted.
- start pulsed during SEND_T of an in-flight element -> ignored; the output stream contains only the first element.
- reset asserted during SEND_T with tx_valid=1 -> tx_valid falls immediately (asynchronous); after release in_ready=1, no stale byte appears, and a new start of 12 -> '1','2',','.

Source files
------------

// File: rtl/ascii_digit_tx_sequencer_pkg.sv
// Shared ASCII constants and FSM state type for the digit serializer.
package ascii_digit_tx_sequencer_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_H,
        ST_SEND_T,
        ST_SEND_O,
        ST_SEND_SEP,
        ST_SEND_CR,
        ST_SEND_LF,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ascii_digit_tx_sequencer.sv
// Serializes one element's three ASCII digits (optionally without leading zeros)
// plus a separator or CR/LF terminator onto a valid/ready byte stream.
module ascii_digit_tx_sequencer
    import ascii_digit_tx_sequencer_pkg::*;
#(
    parameter logic [7:0] SEPARATOR      = ASCII_COMMA,
    parameter bit         SUPPRESS_ZEROS = 1'b1,
    parameter logic [7:0] EOL_CR         = ASCII_CR,
    parameter logic [7:0] EOL_LF         = ASCII_LF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       last,
    input  logic [7:0] hundreds,
    input  logic [7:0] tens,
    input  logic [7:0] ones,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       done
);

    state_e     state_reg;
    logic [7:0] h_reg;
    logic [7:0] t_reg;
    logic [7:0] o_reg;
    logic       last_reg;

    state_e     first_next;
    state_e     adv_next;

    function automatic logic [7:0] byte_of(input state_e s, input logic [7:0] h,
                                           input logic [7:0] t, input logic [7:0] o);
        case (s)
            ST_SEND_H:   return h;
            ST_SEND_T:   return t;
            ST_SEND_O:   return o;
            ST_SEND_SEP: return SEPARATOR;
            ST_SEND_CR:  return EOL_CR;
            ST_SEND_LF:  return EOL_LF;
            default:     return 8'h00;
        endcase
    endfunction

    // Entry state is chosen from the live inputs because they are only valid with start.
    always_comb begin
        first_next = ST_SEND_H;
        if (SUPPRESS_ZEROS) begin
            if (hundreds != ASCII_ZERO)
                first_next = ST_SEND_H;
            else if (tens != ASCII_ZERO)
                first_next = ST_SEND_T;
            else
                first_next = ST_SEND_O;
        end
    end

    always_comb begin
        adv_next = ST_IDLE;
        case (state_reg)
            ST_SEND_H:   adv_next = ST_SEND_T;
            ST_SEND_T:   adv_next = ST_SEND_O;
            ST_SEND_O:   adv_next = last_reg ? ST_SEND_CR : ST_SEND_SEP;
            ST_SEND_CR:  adv_next = ST_SEND_LF;
            ST_SEND_SEP: adv_next = ST_DONE;
            ST_SEND_LF:  adv_next = ST_DONE;
            default:     adv_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            h_reg     <= 8'h00;
            t_reg     <= 8'h00;
            o_reg     <= 8'h00;
            last_reg  <= 1'b0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        h_reg     <= hundreds;
                        t_reg     <= tens;
                        o_reg     <= ones;
                        last_reg  <= last;
                        state_reg <= first_next;
                        tx_valid  <= 1'b1;
                        tx_data   <= byte_of(first_next, hundreds, tens, ones);
                        in_ready  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    in_ready  <= 1'b1;
                end
                default: begin
                    // Outputs hold their value until the UART takes the byte.
                    if (tx_valid && tx_ready) begin
                        state_reg <= adv_next;
                        if (adv_next == ST_DONE) begin
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            done     <= 1'b1;
                        end else begin
                            tx_data <= byte_of(adv_next, h_reg, t_reg, o_reg);
                        end
                    end
                end
            endcase
        end
    end

endmodule
